keyword_tokenizer: RTL and testbench

//  Upstream lexer stage for the begin/end nesting checker. Accepts a byte stream

---
 rtl/tok_pkg.sv | 15 +
 rtl/tok_fifo.sv | 38 +++
 rtl/keyword_tokenizer.sv | 79 +++++++
 tb/tb_keyword_tokenizer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tok_pkg.sv
// tok_pkg: shared token kinds, matcher state encoding and byte classification helpers
package tok_pkg;
  localparam logic [1:0] TOK_OTHER = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;
  typedef enum logic [3:0] {
    S_IDLE, S_B1, S_B2, S_B3, S_B4, S_B5, S_E1, S_E2, S_E3, S_OTHER
  } state_t;
  function automatic logic is_delim(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0a || c == 8'h0d;
  endfunction
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) ? c + 8'h20 : c;
  endfunction
endpackage

// File: rtl/tok_fifo.sv
// tok_fifo: DEPTH-entry token FIFO with registered count; output reads zero while empty
module tok_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/keyword_tokenizer.sv
// keyword_tokenizer: splits a byte stream into words and emits BEGIN/END/OTHER tokens via a FIFO
module keyword_tokenizer
  import tok_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_eos,
  output logic             in_ready,
  output logic             tok_valid,
  output logic [1:0]       tok_kind,
  output logic [LEN_W-1:0] tok_len,
  input  logic             tok_ready,
  output logic             overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_d, ext, word_state;
  logic [LEN_W-1:0] len, len_d, word_len;
  logic [7:0] ch;
  logic accept, delim, sat, term, push, overflow_d, fifo_full, fifo_empty;
  logic [1:0] kind;
  logic [CW-1:0] fifo_count;
  logic [LEN_W+1:0] fifo_dout;
  assign in_ready = fifo_count != CW'(DEPTH);
  assign tok_valid = ~fifo_empty;
  assign {tok_kind, tok_len} = fifo_dout;
  always_comb begin
    ch = fold_case(in_char);
    delim = is_delim(in_char);
    accept = in_valid & in_ready;
    sat = len == '1;
    ext = S_OTHER;
    case (state)
      S_IDLE:  ext = ch == "b" ? S_B1 : ch == "e" ? S_E1 : S_OTHER;
      S_B1:    ext = ch == "e" ? S_B2 : S_OTHER;
      S_B2:    ext = ch == "g" ? S_B3 : S_OTHER;
      S_B3:    ext = ch == "i" ? S_B4 : S_OTHER;
      S_B4:    ext = ch == "n" ? S_B5 : S_OTHER;
      S_E1:    ext = ch == "n" ? S_E2 : S_OTHER;
      S_E2:    ext = ch == "d" ? S_E3 : S_OTHER;
      default: ext = S_OTHER;
    endcase
    // A word byte that would push the length past its maximum loses any keyword match
    word_state = delim ? state : sat ? S_OTHER : ext;
    word_len = (delim || sat) ? len : len + 1'b1;
    term = accept & (delim | in_eos);
    push = term & (word_state != S_IDLE) & ~fifo_full;
    kind = word_state == S_B5 ? TOK_BEGIN : word_state == S_E3 ? TOK_END : TOK_OTHER;
    state_d = !accept ? state : term ? S_IDLE : word_state;
    len_d = !accept ? len : term ? '0 : word_len;
    overflow_d = overflow | (accept & ~delim & sat);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      len <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      len <= len_d;
      overflow <= overflow_d;
    end
  end
  tok_fifo #(.DEPTH(DEPTH), .W(LEN_W + 2)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({kind, word_len}),
    .pop(tok_ready),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_keyword_tokenizer.sv
// tb_keyword_tokenizer: scoreboard bench; expected tokens queued at stimulus, compared on pop
module tb_keyword_tokenizer;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_eos = 0, tok_ready = 1;
  logic [7:0] in_char = 0;
  logic in_ready, tok_valid, overflow;
  logic [1:0] tok_kind;
  logic [7:0] tok_len;
  logic v7 = 0;
  logic [7:0] c7 = 0;
  logic rdy7, tv7, ovf7;
  logic [1:0] k7;
  logic [2:0] l7;
  logic sdone;
  int vectors = 0, miscompares = 0;
  int exp_q[$];
  int e;

  keyword_tokenizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char), .in_eos(in_eos),
    .in_ready(in_ready), .tok_valid(tok_valid), .tok_kind(tok_kind), .tok_len(tok_len),
    .tok_ready(tok_ready), .overflow(overflow)
  );

  keyword_tokenizer #(.DEPTH(4), .LEN_W(3)) dut7 (
    .clk(clk), .reset(reset), .in_valid(v7), .in_char(c7), .in_eos(1'b0),
    .in_ready(rdy7), .tok_valid(tv7), .tok_kind(k7), .tok_len(l7),
    .tok_ready(1'b1), .overflow(ovf7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && tok_valid && tok_ready) begin
      if (exp_q.size() == 0) check("extra_token", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("tok_kind", int'(tok_kind), e >> 8);
        check("tok_len", int'(tok_len), e & 255);
      end
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_tok(input int kind, input int len);
    exp_q.push_back(kind * 256 + len);
  endtask

  task automatic send(input logic [7:0] c, input logic eos);
    in_valid = 1;
    in_char = c;
    in_eos = eos;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    step(1);
    in_valid = 0;
    in_eos = 0;
  endtask

  task automatic send_str(input string s, input logic eos_last);
    for (int i = 0; i < s.len(); i++) send(s[i], eos_last && i == s.len() - 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_idle"}, int'(tok_valid), 0);
    step(1);
  endtask

  // Stall the consumer, fill the FIFO, then release and let the scoreboard check order
  task automatic backpressure(input string tag, input string s, input int head_kind, input int head_len);
    tok_ready = 0;
    sdone = 0;
    fork
      begin
        send_str(s, 1'b0);
        sdone = 1;
      end
    join_none
    repeat (30) @(negedge clk);
    check({tag, "_in_ready_full"}, int'(in_ready), 0);
    check({tag, "_stalled"}, int'(sdone), 0);
    check({tag, "_head_kind"}, int'(tok_kind), head_kind);
    check({tag, "_head_len"}, int'(tok_len), head_len);
    @(negedge clk);
    check({tag, "_hold_len"}, int'(tok_len), head_len);
    step(1);
    tok_ready = 1;
    for (int i = 0; i < 200 && !sdone; i++) @(negedge clk);
    check({tag, "_send_done"}, int'(sdone), 1);
    drain(tag);
  endtask

  initial begin
    step(2);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_tok_valid", int'(tok_valid), 0);
    check("rst_tok_kind", int'(tok_kind), 0);
    check("rst_tok_len", int'(tok_len), 0);
    check("rst_overflow", int'(overflow), 0);
    step(1);
    reset = 0;
    step(1);

    expect_tok(1, 5); expect_tok(2, 3);
    send_str("begin end ", 1'b0);
    drain("t1");

    expect_tok(1, 5); expect_tok(2, 3);
    send_str("BeGiN\tEnD\n", 1'b0);
    drain("t2");

    expect_tok(0, 6); expect_tok(0, 4); expect_tok(0, 2);
    send_str("beginx endd be ", 1'b0);
    drain("t3");

    for (int i = 0; i < 5; i++) expect_tok(0, 1);
    backpressure("t4", "a b c d e ", 0, 1);

    expect_tok(1, 5); expect_tok(0, 2); expect_tok(2, 3); expect_tok(0, 3); expect_tok(0, 1);
    backpressure("t4b", "Begin xx END\ryyy\tz ", 1, 5);

    expect_tok(2, 3);
    send_str("   ", 1'b0);
    send_str("end", 1'b1);
    drain("t5");

    send_str("beg", 1'b0);
    reset = 1;
    step(1);
    reset = 0;
    @(negedge clk);
    check("t6_after_reset_valid", int'(tok_valid), 0);
    check("t6_after_reset_ready", int'(in_ready), 1);
    step(1);
    expect_tok(0, 2);
    send_str("in ", 1'b0);
    drain("t6");
    check("main_overflow", int'(overflow), 0);

    for (int i = 0; i < 9; i++) begin
      v7 = 1;
      c7 = "x";
      step(1);
    end
    c7 = " ";
    step(1);
    v7 = 0;
    @(negedge clk);
    check("t7_valid", int'(tv7), 1);
    check("t7_kind", int'(k7), 0);
    check("t7_len", int'(l7), 7);
    check("t7_overflow", int'(ovf7), 1);
    step(3);
    @(negedge clk);
    check("t7_popped", int'(tv7), 0);
    check("t7_overflow_sticky", int'(ovf7), 1);
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    @(negedge clk);
    check("t7_overflow_reset", int'(ovf7), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
